// File: rtl/mode_ctrl_if.sv
// rtl/mode_ctrl_if.sv - shared buttons, ring requests and display bus of the mode scheduler
interface mode_ctrl_if;
  logic         btn_mode;
  logic         up, down, left, right, enter, esc;
  logic [3:0]   norm_in;
  logic [3:0]   alm_in;
  logic [191:0] disp_in;
  logic [3:0]   mode_en;
  logic [3:0]   up_o, down_o, left_o, right_o, enter_o, esc_o;
  logic [47:0]  disp_out;
  logic         buzzer;
  logic [1:0]   cur_mode;

  modport master (
    output btn_mode, up, down, left, right, enter, esc, norm_in, alm_in, disp_in,
    input  mode_en, up_o, down_o, left_o, right_o, enter_o, esc_o, disp_out, buzzer, cur_mode
  );

  modport slave (
    input  btn_mode, up, down, left, right, enter, esc, norm_in, alm_in, disp_in,
    output mode_en, up_o, down_o, left_o, right_o, enter_o, esc_o, disp_out, buzzer, cur_mode
  );
endinterface

// File: rtl/mode_ctrl.sv
// rtl/mode_ctrl.sv - function scheduler: button routing, display mux, ring preemption and acknowledge
module mode_ctrl #(
  parameter int          RING_CYCLES = 60000,
  parameter int          BLINK_HALF  = 500,
  parameter logic [47:0] BLANK       = 48'hFFFF_FFFF_FFFF
) (
  input logic        clk,
  input logic        rst,
  mode_ctrl_if.slave bus
);
  typedef enum logic [1:0] {BROWSE, LOCKED, RING, ACK} state_t;

  state_t      state;
  logic [1:0]  cur_mode, saved, src, ack_cnt, alm_src;
  logic [3:0]  mode_en, sel;
  logic [3:0]  up_o, down_o, left_o, right_o, enter_o, esc_o;
  logic [16:0] ring_timer;
  logic [9:0]  flash_cnt;
  logic        flash_off, buzzer, forward;
  logic [6:0]  btns, btn_q, btn_rise;
  logic [47:0] disp_out, disp_sel;

  assign btns     = {bus.btn_mode, bus.up, bus.down, bus.left, bus.right, bus.enter, bus.esc};
  assign btn_rise = btns & ~btn_q;
  assign sel      = 4'b0001 << cur_mode;
  assign forward  = (state == BROWSE) || (state == LOCKED);
  assign alm_src  = bus.alm_in[0] ? 2'd0 : bus.alm_in[1] ? 2'd1 : bus.alm_in[2] ? 2'd2 : 2'd3;

  always_comb begin
    disp_sel = bus.disp_in[47:0];
    case (cur_mode)
      2'd0: disp_sel = bus.disp_in[47:0];
      2'd1: disp_sel = bus.disp_in[95:48];
      2'd2: disp_sel = bus.disp_in[143:96];
      2'd3: disp_sel = bus.disp_in[191:144];
      default: disp_sel = bus.disp_in[47:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BROWSE;
      cur_mode   <= 2'd0;
      saved      <= 2'd0;
      src        <= 2'd0;
      mode_en    <= 4'b0001;
      ack_cnt    <= 2'd0;
      ring_timer <= '0;
      flash_cnt  <= '0;
      flash_off  <= 1'b0;
      buzzer     <= 1'b0;
      btn_q      <= '0;
      up_o       <= '0;
      down_o     <= '0;
      left_o     <= '0;
      right_o    <= '0;
      enter_o    <= '0;
      esc_o      <= '0;
      disp_out   <= '0;
    end else begin
      btn_q    <= btns;
      up_o     <= (forward && bus.up)    ? sel : 4'b0;
      down_o   <= (forward && bus.down)  ? sel : 4'b0;
      left_o   <= (forward && bus.left)  ? sel : 4'b0;
      right_o  <= (forward && bus.right) ? sel : 4'b0;
      enter_o  <= (forward && bus.enter) ? sel : 4'b0;
      esc_o    <= (forward && bus.esc)   ? sel : 4'b0;
      disp_out <= (state == RING && flash_off) ? BLANK : disp_sel;
      case (state)
        BROWSE, LOCKED: begin
          // A ring request outranks both edit lock and a same-cycle mode press
          if (|bus.alm_in) begin
            state      <= RING;
            saved      <= cur_mode;
            src        <= alm_src;
            cur_mode   <= alm_src;
            mode_en    <= 4'b0001 << alm_src;
            buzzer     <= 1'b1;
            ring_timer <= '0;
            flash_cnt  <= '0;
            flash_off  <= 1'b0;
          end else if (state == LOCKED) begin
            if (bus.norm_in[cur_mode]) state <= BROWSE;
          end else if (!bus.norm_in[cur_mode]) begin
            state <= LOCKED;
          end else if (btn_rise[6]) begin
            cur_mode <= cur_mode + 2'd1;
            mode_en  <= {mode_en[2:0], mode_en[3]};
          end
        end
        RING: begin
          if (!bus.alm_in[src]) begin
            state    <= BROWSE;
            cur_mode <= saved;
            mode_en  <= 4'b0001 << saved;
            buzzer   <= 1'b0;
          end else if ((|btn_rise) || ring_timer == 17'(RING_CYCLES - 1)) begin
            state   <= ACK;
            buzzer  <= 1'b0;
            ack_cnt <= 2'd0;
            esc_o   <= 4'b0001 << src;
          end else begin
            if (ring_timer != '1) ring_timer <= ring_timer + 17'd1;
            if (flash_cnt == 10'(BLINK_HALF - 1)) begin
              flash_cnt <= '0;
              flash_off <= ~flash_off;
            end else begin
              flash_cnt <= flash_cnt + 10'd1;
            end
          end
        end
        ACK: begin
          // Source still ringing: re-issue the escape every fourth cycle
          if (!bus.alm_in[src]) begin
            state    <= BROWSE;
            cur_mode <= saved;
            mode_en  <= 4'b0001 << saved;
          end else if (ack_cnt == 2'd3) begin
            ack_cnt <= 2'd0;
            esc_o   <= 4'b0001 << src;
          end else begin
            ack_cnt <= ack_cnt + 2'd1;
          end
        end
        default: state <= BROWSE;
      endcase
    end
  end

  assign bus.mode_en  = mode_en;
  assign bus.up_o     = up_o;
  assign bus.down_o   = down_o;
  assign bus.left_o   = left_o;
  assign bus.right_o  = right_o;
  assign bus.enter_o  = enter_o;
  assign bus.esc_o    = esc_o;
  assign bus.disp_out = disp_out;
  assign bus.buzzer   = buzzer;
  assign bus.cur_mode = cur_mode;
endmodule

// File: tb/tb_mode_ctrl.sv
// tb/tb_mode_ctrl.sv - scoreboard bench for mode_ctrl against a behavioural model
module tb_mode_ctrl;
  localparam int          BLINK_HALF  = 500;
  localparam int          RING_CYCLES = 60000;
  localparam logic [47:0] BLANK       = 48'hFFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mode_ctrl_if bus ();
  mode_ctrl #(.RING_CYCLES(RING_CYCLES), .BLINK_HALF(BLINK_HALF), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [78:0] exp_q[$];

  // Behavioural view: mode index, flags for ringing / acknowledging / edit lock, and ages
  int  m_mode, m_saved, m_src, m_ring_age, m_ack_age;
  bit  m_ring, m_ack, m_locked;
  logic [6:0] m_prev;

  function automatic logic [78:0] dut_word();
    return {bus.mode_en, bus.up_o, bus.down_o, bus.left_o, bus.right_o, bus.enter_o,
            bus.esc_o, bus.disp_out, bus.buzzer, bus.cur_mode};
  endfunction

  task automatic model_step();
    logic [6:0]      b, rise;
    logic [5:0][3:0] route;
    logic [47:0]     disp;
    bit              pulse;
    b     = {bus.btn_mode, bus.up, bus.down, bus.left, bus.right, bus.enter, bus.esc};
    rise  = b & ~m_prev;
    route = '0;
    pulse = 0;
    if (rst) begin
      m_mode = 0; m_saved = 0; m_src = 0; m_ring = 0; m_ack = 0; m_locked = 0;
      m_ring_age = 0; m_ack_age = 0; m_prev = '0;
      exp_q.push_back({4'b0001, 24'h0, 48'h0, 1'b0, 2'd0});
      return;
    end
    if (!m_ring && !m_ack)
      for (int k = 0; k < 6; k++) if (b[k]) route[k][m_mode] = 1'b1;
    disp = (m_ring && ((m_ring_age / BLINK_HALF) % 2 == 1)) ? BLANK : bus.disp_in[48*m_mode +: 48];
    if (m_ring) begin
      if (!bus.alm_in[m_src]) begin
        m_ring = 0; m_mode = m_saved; m_locked = 0;
      end else if (rise != 0 || m_ring_age == RING_CYCLES - 1) begin
        m_ring = 0; m_ack = 1; m_ack_age = 0; pulse = 1;
      end else begin
        m_ring_age++;
      end
    end else if (m_ack) begin
      if (!bus.alm_in[m_src]) begin
        m_ack = 0; m_mode = m_saved; m_locked = 0;
      end else begin
        m_ack_age++;
        if (m_ack_age % 4 == 0) pulse = 1;
      end
    end else if (bus.alm_in != 0) begin
      for (int k = 3; k >= 0; k--) if (bus.alm_in[k]) m_src = k;
      m_saved = m_mode; m_mode = m_src; m_ring = 1; m_ring_age = 0; m_locked = 0;
    end else if (m_locked) begin
      if (bus.norm_in[m_mode]) m_locked = 0;
    end else if (!bus.norm_in[m_mode]) begin
      m_locked = 1;
    end else if (rise[6]) begin
      m_mode = (m_mode + 1) % 4;
    end
    if (pulse) route[0][m_src] = 1'b1;
    m_prev = b;
    exp_q.push_back({4'(1 << m_mode), route, disp, m_ring ? 1'b1 : 1'b0, 2'(m_mode)});
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every edge produces one output word to compare
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL cycle %0d outputs: got %h expected <none queued>", cyc, dut_word());
      end else begin
        logic [78:0] e;
        e = exp_q.pop_front();
        if (dut_word() !== e) begin
          n_bad++;
          $display("FAIL cycle %0d outputs: got %h expected %h", cyc, dut_word(), e);
        end
      end
    end
  end

  task automatic press_mode();
    bus.btn_mode = 1'b1; tick();
    bus.btn_mode = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1;
    {bus.btn_mode, bus.up, bus.down, bus.left, bus.right, bus.enter, bus.esc} = '0;
    bus.norm_in = 4'hF;
    bus.alm_in  = 4'h0;
    for (int k = 0; k < 6; k++) bus.disp_in[32*k +: 32] = $urandom;
    tick(); tick();
    check("reset cur_mode", 64'(bus.cur_mode), 64'd0);
    check("reset mode_en", 64'(bus.mode_en), 64'h1);
    check("reset buzzer", 64'(bus.buzzer), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) press_mode();
    check("mode after 5 presses", 64'(bus.cur_mode), 64'd1);
    check("mode_en after 5 presses", 64'(bus.mode_en), 64'h2);

    press_mode();
    bus.norm_in = 4'b1011; tick();
    press_mode();
    check("locked ignores press", 64'(bus.cur_mode), 64'd2);
    bus.norm_in = 4'hF; tick();
    press_mode();
    check("unlocked press", 64'(bus.cur_mode), 64'd3);
    press_mode();

    bus.alm_in = 4'b0110; tick();
    check("ring src lowest", 64'(bus.cur_mode), 64'd1);
    check("ring buzzer", 64'(bus.buzzer), 64'd1);
    repeat (600) tick();
    check("flash off phase", 64'(bus.disp_out), 64'(BLANK));
    bus.enter = 1'b1; tick();
    check("ack esc pulse", 64'(bus.esc_o), 64'h2);
    bus.enter = 1'b0; tick();
    check("esc pulse one cycle", 64'(bus.esc_o), 64'h0);
    bus.alm_in = 4'b0100; tick();
    check("restore saved mode", 64'(bus.cur_mode), 64'd0);
    tick();
    check("queued ring src", 64'(bus.cur_mode), 64'd2);

    repeat (RING_CYCLES + 10) begin
      if ($urandom_range(999) == 0) bus.disp_in[$urandom_range(191)] ^= 1'b1;
      tick();
    end
    check("auto ack buzzer", 64'(bus.buzzer), 64'd0);
    bus.alm_in = 4'b0000; tick();
    check("restore after auto ack", 64'(bus.cur_mode), 64'd0);

    press_mode();
    bus.norm_in = 4'b1101; tick();
    bus.alm_in = 4'b1000; bus.btn_mode = 1'b1; tick();
    check("alarm beats press", 64'(bus.cur_mode), 64'd3);
    bus.btn_mode = 1'b0; tick();
    bus.up = 1'b1; tick();
    bus.up = 1'b0; bus.alm_in = 4'b0000; tick();
    check("restore from locked", 64'(bus.cur_mode), 64'd1);
    bus.norm_in = 4'hF; tick();

    bus.alm_in = 4'b0001; repeat (10) tick();
    rst = 1'b1; tick();
    check("reset mid ring mode", 64'(bus.cur_mode), 64'd0);
    check("reset mid ring buzzer", 64'(bus.buzzer), 64'd0);
    check("reset mid ring esc", 64'(bus.esc_o), 64'h0);
    rst = 1'b0; bus.alm_in = 4'b0000; tick();

    bus.alm_in = 4'b0100; repeat (20) tick();
    bus.alm_in = 4'b0000; tick();
    check("self clear mode", 64'(bus.cur_mode), 64'd0);
    check("self clear no esc", 64'(bus.esc_o), 64'h0);

    repeat (4000) begin
      logic [6:0] b;
      b = {bus.btn_mode, bus.up, bus.down, bus.left, bus.right, bus.enter, bus.esc};
      for (int k = 0; k < 7; k++) if ($urandom_range(7) == 0) b[k] = ~b[k];
      {bus.btn_mode, bus.up, bus.down, bus.left, bus.right, bus.enter, bus.esc} = b;
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(299) == 0) bus.alm_in[k] = ~bus.alm_in[k];
        if ($urandom_range(59) == 0) bus.norm_in[k] = ~bus.norm_in[k];
      end
      bus.disp_in[32*$urandom_range(5) +: 32] = $urandom;
      rst = ($urandom_range(999) == 0);
      tick();
    end

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
